ball_ctl: RTL
=============

# ball_ctl

Per-frame ball motion controller for the PONG video pipeline. It owns the ball's `xpos`/`ypos` registers, which drive the ball-drawing stage, and updates them once per frame during vertical blanking, so the drawn position never changes mid-frame. It bounces the ball off the top and bottom walls and off both paddles. When a player misses, it flags the point, holds the ball, and returns to a serve-ready state.

## Interface
Parameters:
- `H_RES`, 800: active width in pixels.
- `V_RES`, 600: active height in pixels.
- `BALL_SIZE`, 16: ball edge length in pixels; must match the draw stage.
- `SPEED`, 4: pixels moved per axis per frame.
- `PADDLE_W`, 8: paddle width in pixels.
- `PADDLE_H`, 64: paddle height in pixels.
- `LEFT_PADDLE_X`, 16: x of the left paddle's left edge.
- `RIGHT_PADDLE_X`, 776: x of the right paddle's left edge.
- `SERVE_X`, 392 / `SERVE_Y`, 292: ball top-left position at serve.
- `HOLD_FRAMES`, 60: frames the ball is frozen after a point.

Ports:
- `pclk`, in, 1: pixel clock; single clock domain.
- `rst`, in, 1: asynchronous, active-low reset.
- `vblnk_in`, in, 1: vertical blank from the timing generator.
- `game_en`, in, 1: level signal; low forces IDLE.
- `serve`, in, 1: one-cycle serve request.
- `paddle_l_y`, in, 12: left paddle top y.
- `paddle_r_y`, in, 12: right paddle top y.
- `xpos`, out, 12: ball top-left x (registered).
- `ypos`, out, 12: ball top-left y (registered).
- `point_l`, out, 1: one-cycle pulse; the left player scored.
- `point_r`, out, 1: one-cycle pulse; the right player scored.
- `ball_active`, out, 1: high while in MOVE.

## Operation
- **Frame tick.** `tick` = `vblnk_in` & ~`vblnk_q`, where `vblnk_q` is `vblnk_in` registered. There is one tick per frame.
- **Direction state.** `dx` (1 = right) and `dy` (1 = down) are internal registers.
- **IDLE.**
  - Ball held at (`SERVE_X`, `SERVE_Y`).
  - `serve` & `game_en` → MOVE. `dx` toggles on entry; `dy` is kept.
  - Movement starts on the next tick after entry.
- **MOVE.** On each tick, the vertical and horizontal updates are evaluated in the same cycle from the current x/y.
- **Vertical update:**
  - Moving down and `ypos`+`SPEED` ≥ `V_RES`−`BALL_SIZE` → `ypos` = `V_RES`−`BALL_SIZE`, `dy`=0.
  - Moving up and `ypos` < `SPEED` → `ypos`=0, `dy`=1.
  - Otherwise `ypos` ± `SPEED`.
- **Left paddle overlap** means `ypos`+`BALL_SIZE` > `paddle_l_y` and `ypos` < `paddle_l_y`+`PADDLE_H`. Right overlap uses `paddle_r_y` the same way.
- **Horizontal update, moving left** (checks in priority order):
  - Paddle hit: `xpos` ≥ `LEFT_PADDLE_X`+`PADDLE_W`, `xpos`−`SPEED` ≤ that value, and left overlap → `xpos` = `LEFT_PADDLE_X`+`PADDLE_W`, `dx`=1.
  - Miss: else if `xpos` < `SPEED` → `xpos`=0, pulse `point_r`, → HOLD.
  - Otherwise `xpos`−`SPEED`.
- **Horizontal update, moving right** (same structure, mirrored):
  - Paddle hit: the paddle face is `RIGHT_PADDLE_X`−`BALL_SIZE`. If `xpos` ≤ face, `xpos`+`SPEED` ≥ face, and right overlap → `xpos` = face, `dx`=0.
  - Miss: else if `xpos`+`SPEED` ≥ `H_RES`−`BALL_SIZE` → `xpos` = `H_RES`−`BALL_SIZE`, pulse `point_l`, → HOLD.
  - Otherwise `xpos`+`SPEED`.
- **Paddle checks after a pass.** Once the ball is past a paddle face, that paddle is never checked again; the ball continues to the screen edge.
- **HOLD.**
  - Ball frozen in place.
  - An 8-bit frame counter counts ticks.
  - After `HOLD_FRAMES` ticks → IDLE and the ball returns to the serve position.
- **`game_en` low.** From any state → IDLE on the next `pclk`. Ball goes to the serve position, the hold counter clears, and no point pulse is produced.
- **`serve` outside IDLE.** Ignored.
- **Arithmetic.** Unsigned, 13-bit internal sums to avoid wrap. Outputs stay in [0, `H_RES`−`BALL_SIZE`] × [0, `V_RES`−`BALL_SIZE`].

## Timing
- **Reset values** (`rst`=0, asynchronous):
  - `xpos`=`SERVE_X`, `ypos`=`SERVE_Y`.
  - `point_l`=`point_r`=0, `ball_active`=0.
  - State IDLE, `dx`=1, `dy`=1, hold counter 0, `vblnk_q`=0.
- **Update latency.**
  - The tick is detected in the first `pclk` edge where `vblnk_in`=1 and `vblnk_q`=0.
  - `xpos`/`ypos` and the point pulses update on that same edge.
  - All outputs are therefore stable for the remainder of blanking and the whole next active frame.
- **Point pulses.** Exactly one `pclk` wide, coincident with the clamped position. The state is HOLD from the next cycle.
- **`ball_active`.** Registered; equals (state==MOVE), with one cycle of latency after the state register.
- **`serve` and tick in the same IDLE cycle.** Go to MOVE with no movement; the first move happens on the following frame.
- **Paddle inputs.** Sampled only on tick cycles.
- **Reset deasserted mid-frame.** The first tick is the next rising edge of `vblnk_in`; a `vblnk_in` already high gives no tick.

## Test plan
- **Reset.** Assert `rst`=0 mid-run → `xpos`=392, `ypos`=292, `ball_active`=0, no pulses. Release with `vblnk_in` high → no move until the next rising edge.
- **Serve and free motion.** Serve (`dx` toggles to 0) with paddles out of the way → per frame, `xpos` 392→388→384 and `ypos` 292→296→300. `ball_active`=1 one cycle after MOVE.
- **Wall bounce.** Ball at `ypos`=582 moving down → 584 with `dy`=0, then 580.
- **Left paddle hit.** `paddle_l_y`=280, ball at `xpos`=26 moving left → `xpos`=24, `dx`=1, then 28. No `point_r`.
- **Miss, hold and return.**
  - Paddle at y=0, ball moving left at `xpos`=2 → `xpos`=0 and a one-cycle `point_r`.
  - Ball stays frozen for 60 frames, then returns to (392, 292) in IDLE.
  - The next serve goes right.
- **Disable mid-rally.** `game_en`=0 in MOVE → IDLE next cycle at (392, 292), no pulse. `serve` while `game_en`=0 → stays IDLE.

Source files
------------

// File: rtl/ball_ctl.sv
// Ball motion controller: moves the ball once per frame at the start of vertical blanking, bounces it off walls and paddles, scores misses.
// Latency: xpos/ypos and point pulses update on the first pclk edge with vblnk_in high; ball_active lags the state register by one cycle.
// Backpressure: none; inputs are levels or single-cycle pulses, outputs are held registers until the next frame tick.
// Ports: pclk/rst (async, active-low); vblnk_in frame timing; game_en enable level; serve one-cycle request;
//        paddle_l_y/paddle_r_y paddle tops; xpos/ypos ball top-left; point_l/point_r score pulses; ball_active high in MOVE.
module ball_ctl #(
  parameter int H_RES          = 800,
  parameter int V_RES          = 600,
  parameter int BALL_SIZE      = 16,
  parameter int SPEED          = 4,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 776,
  parameter int SERVE_X        = 392,
  parameter int SERVE_Y        = 292,
  parameter int HOLD_FRAMES    = 60
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        game_en,
  input  logic        serve,
  input  logic [11:0] paddle_l_y,
  input  logic [11:0] paddle_r_y,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        point_l,
  output logic        point_r,
  output logic        ball_active
);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, HOLD = 2'd2} state_t;

  // 13-bit working width so sums never wrap before the range checks.
  localparam logic [12:0] X_MAX     = 13'(H_RES - BALL_SIZE);
  localparam logic [12:0] Y_MAX     = 13'(V_RES - BALL_SIZE);
  localparam logic [12:0] L_FACE    = 13'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [12:0] R_FACE    = 13'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic [12:0] SPD       = 13'(SPEED);
  localparam logic [12:0] BSZ       = 13'(BALL_SIZE);
  localparam logic [12:0] PHT       = 13'(PADDLE_H);
  localparam logic [11:0] SRV_X     = 12'(SERVE_X);
  localparam logic [11:0] SRV_Y     = 12'(SERVE_Y);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);

  state_t      state_q, state_d;
  logic        vblnk_q, tick;
  logic        dx, dy, dx_d, dy_d;
  logic [7:0]  hold_cnt, hold_cnt_d;
  logic [11:0] xpos_d, ypos_d;
  logic        point_l_d, point_r_d, ball_active_d;

  logic [12:0] x_ext, y_ext, pl_top, pr_top;
  logic [11:0] x_mv, y_mv;
  logic        dx_mv, dy_mv;
  logic        ovl_l, ovl_r, hit_l, hit_r, score_l, score_r;

  assign tick = vblnk_in & ~vblnk_q;

  // Candidate position/direction for a MOVE tick, from the current x/y.
  always_comb begin
    x_ext  = {1'b0, xpos};
    y_ext  = {1'b0, ypos};
    pl_top = {1'b0, paddle_l_y};
    pr_top = {1'b0, paddle_r_y};
    ovl_l  = (y_ext + BSZ > pl_top) && (y_ext < pl_top + PHT);
    ovl_r  = (y_ext + BSZ > pr_top) && (y_ext < pr_top + PHT);
    // Once past a face the range test can no longer hold, so a passed
    // paddle is never hit again and the ball runs on to the edge.
    hit_l   = !dx && (x_ext >= L_FACE) && (x_ext <= L_FACE + SPD) && ovl_l;
    hit_r   =  dx && (x_ext <= R_FACE) && (x_ext + SPD >= R_FACE) && ovl_r;
    score_r = !dx && !hit_l && (x_ext < SPD);
    score_l =  dx && !hit_r && (x_ext + SPD >= X_MAX);

    y_mv  = ypos;
    dy_mv = dy;
    if (dy) begin
      if (y_ext + SPD >= Y_MAX) begin
        y_mv  = Y_MAX[11:0];
        dy_mv = 1'b0;
      end else begin
        y_mv = 12'(y_ext + SPD);
      end
    end else if (y_ext < SPD) begin
      y_mv  = '0;
      dy_mv = 1'b1;
    end else begin
      y_mv = 12'(y_ext - SPD);
    end

    x_mv  = xpos;
    dx_mv = dx;
    if (hit_l) begin
      x_mv  = L_FACE[11:0];
      dx_mv = 1'b1;
    end else if (score_r) begin
      x_mv = '0;
    end else if (!dx) begin
      x_mv = 12'(x_ext - SPD);
    end else if (hit_r) begin
      x_mv  = R_FACE[11:0];
      dx_mv = 1'b0;
    end else if (score_l) begin
      x_mv = X_MAX[11:0];
    end else begin
      x_mv = 12'(x_ext + SPD);
    end
  end

  // State register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; game_en low overrides everything.
  always_comb begin
    state_d = state_q;
    if (!game_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (serve) state_d = MOVE;
        MOVE:    if (tick && (score_l || score_r)) state_d = HOLD;
        HOLD:    if (tick && (hold_cnt == HOLD_LAST)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    xpos_d        = xpos;
    ypos_d        = ypos;
    dx_d          = dx;
    dy_d          = dy;
    hold_cnt_d    = hold_cnt;
    point_l_d     = 1'b0;
    point_r_d     = 1'b0;
    ball_active_d = (state_q == MOVE);
    if (!game_en) begin
      xpos_d     = SRV_X;
      ypos_d     = SRV_Y;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          xpos_d = SRV_X;
          ypos_d = SRV_Y;
          // Alternate serve direction; a tick in this cycle does not move the ball.
          if (serve) dx_d = ~dx;
        end
        MOVE: begin
          if (tick) begin
            xpos_d    = x_mv;
            ypos_d    = y_mv;
            dx_d      = dx_mv;
            dy_d      = dy_mv;
            point_l_d = score_l;
            point_r_d = score_r;
          end
        end
        HOLD: begin
          if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt_d = '0;
              xpos_d     = SRV_X;
              ypos_d     = SRV_Y;
            end else begin
              hold_cnt_d = hold_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vblnk_q     <= 1'b0;
      xpos        <= SRV_X;
      ypos        <= SRV_Y;
      dx          <= 1'b1;
      dy          <= 1'b1;
      hold_cnt    <= '0;
      point_l     <= 1'b0;
      point_r     <= 1'b0;
      ball_active <= 1'b0;
    end else begin
      vblnk_q     <= vblnk_in;
      xpos        <= xpos_d;
      ypos        <= ypos_d;
      dx          <= dx_d;
      dy          <= dy_d;
      hold_cnt    <= hold_cnt_d;
      point_l     <= point_l_d;
      point_r     <= point_r_d;
      ball_active <= ball_active_d;
    end
  end

endmodule
